dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/load_align.sv | 39 +++
 rtl/dmem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and types for the data-memory controller:
//                access size encodings, FSM state enum, timeout default.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;   // 2'b11 also decodes as word

    localparam int c_timeout_default = 255;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_req  = 2'd1,
        st_wait = 2'd2,
        st_done = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Selects the addressed byte/half lane of a memory word and
//                sign- or zero-extends it to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane, then extend it according to size/signedness.
    always_comb begin
        w_byte = word[7:0];
        case (addr)
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            2'd3:    w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        w_half = addr[1] ? word[31:16] : word[15:0];
        case (size)
            c_sz_byte: value = {{24{w_byte[7] & ~ld_unsigned}}, w_byte};
            c_sz_half: value = {{16{w_half[15] & ~ld_unsigned}}, w_half};
            default:   value = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : Data-memory controller between the CPU datapath and a
//                request/grant memory bus. Handles alignment checks, byte
//                enables, store replication, load extension and timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int                 c_cnt_w   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_rdata;
    logic [29:0]        r_waddr;
    logic [1:0]         r_lane;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [1:0]         r_size;
    logic               r_uns;
    logic               r_we;

    logic               w_aligned;
    logic               w_start;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load;

    // Decode alignment, byte enables and lane-replicated store data.
    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = wdata;
        case (size)
            c_sz_byte: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            c_sz_half: begin
                w_aligned = ~addr[0];
                w_be      = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{wdata[15:0]}};
            end
            default: w_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign w_timeout = ((r_state == st_req) || (r_state == st_wait)) && (r_cnt == c_cnt_max);

    // Next-state and control outputs; reset forces every output low at once.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        bus_err  = 1'b0;
        mem_req  = 1'b0;
        rdata    = '0;
        case (r_state)
            st_idle: begin
                if (memread || memwrite) begin
                    if (w_aligned) begin
                        stall   = 1'b1;
                        w_start = 1'b1;
                        w_next  = st_req;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            st_req: begin
                stall = 1'b1;
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = st_done;
                end else begin
                    mem_req = 1'b1;
                    if (mem_gnt) w_next = r_we ? st_done : st_wait;
                end
            end
            st_wait: begin
                stall = 1'b1;
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = st_done;
                end else if (mem_rvalid) begin
                    w_next = st_done;
                end
            end
            st_done: begin
                rdata  = r_rdata;
                w_next = st_idle;
            end
            default: w_next = st_idle;
        endcase
        if (reset) begin
            stall    = 1'b0;
            misalign = 1'b0;
            bus_err  = 1'b0;
            mem_req  = 1'b0;
            rdata    = '0;
            w_start  = 1'b0;
        end
    end

    // Bus fields come from the captured request and are zero when idle.
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = mem_req ? {r_waddr, 2'b00} : '0;
    assign mem_be    = mem_req ? r_be : '0;
    assign mem_wdata = mem_req ? r_wdata : '0;

    load_align u_load_align (
        .word        (mem_rdata),
        .addr        (r_lane),
        .size        (r_size),
        .ld_unsigned (r_uns),
        .value       (w_load)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= st_idle;
        else       r_state <= w_next;
    end

    // Capture the request, run the timeout counter and latch load results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_waddr <= '0;
            r_lane  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_waddr <= addr[31:2];
            r_lane  <= addr[1:0];
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_size  <= size;
            r_uns   <= ld_unsigned;
            r_we    <= memwrite;
        end else if ((r_state == st_req) || (r_state == st_wait)) begin
            r_cnt <= r_cnt + c_cnt_one;
            if (w_timeout)
                r_rdata <= '0;
            else if ((r_state == st_wait) && mem_rvalid)
                r_rdata <= w_load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Self-checking bench for dmem_ctrl: directed vector table,
//                randomized accesses against a reference model, and
//                hand-written timeout and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, ld_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        stall, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, wd, rdat;
        int          gdly;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] mwd, rres;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-count arithmetic on the access rules.
    function automatic void model(input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rdat, output logic mis,
                                  output logic [3:0] be, output logic [31:0] mwd,
                                  output logic [31:0] rres);
        int     nb, off;
        longint v, span;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off  = int'(a[1:0]);
        mis  = (off % nb) != 0;
        be   = 4'(((1 << nb) - 1) << off);
        mwd  = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
               (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        span = longint'(1) << (8 * nb);
        v    = (longint'(rdat) >> (8 * off)) % span;
        if (!uns && nb < 4 && v >= span / 2) v = v - span;
        rres = 32'(v);
    endfunction

    // One complete access as seen from the datapath, checked cycle by cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int gdly, input int rdly,
                              input logic e_mis, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_rd);
        @(negedge clk);
        memread = rd; memwrite = wr; size = sz; ld_unsigned = uns;
        addr = a; wdata = wd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        if (e_mis) begin
            check("mis_pulse", misalign, 1'b1);
            check("mis_stall", stall, 1'b0);
            check("mis_req", mem_req, 1'b0);
            check("mis_rdata", rdata, 32'h0);
            memread = 1'b0; memwrite = 1'b0;
            @(negedge clk); #1;
            check("mis_after_stall", stall, 1'b0);
            check("mis_after_req", mem_req, 1'b0);
            return;
        end
        check("idle_stall", stall, 1'b1);
        check("idle_req", mem_req, 1'b0);
        check("idle_mis", misalign, 1'b0);
        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk);
            mem_gnt    = (i == gdly);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            #1;
            check("req_valid", mem_req, 1'b1);
            check("req_stall", stall, 1'b1);
            check("req_we", mem_we, wr);
            check("req_addr", mem_addr, a & ~32'h3);
            check("req_be", mem_be, e_be);
            if (wr) check("req_wdata", mem_wdata, e_wd);
        end
        if (!wr) begin
            for (int i = 0; i <= rdly; i++) begin
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = (i == rdly);
                mem_rdata  = (i == rdly) ? rdat : $urandom;
                #1;
                check("wait_stall", stall, 1'b1);
                check("wait_req", mem_req, 1'b0);
            end
        end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1;
        check("done_stall", stall, 1'b0);
        check("done_err", bus_err, 1'b0);
        check("done_req", mem_req, 1'b0);
        if (!wr) check("done_rdata", rdata, e_rd);
        memread = 1'b0; memwrite = 1'b0;
    endtask

    // Access that never completes: bus_err must fire when the counter hits TO.
    task automatic run_timeout(input logic is_read);
        int seen;
        seen = -1;
        @(negedge clk);
        memread = is_read; memwrite = ~is_read; size = 2'b10; ld_unsigned = 1'b0;
        addr = 32'h40; wdata = 32'h5A5A5A5A; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("to_start_stall", stall, 1'b1);
        for (int k = 0; k < TO + 64 && seen < 0; k++) begin
            @(negedge clk);
            mem_gnt = is_read && (k == 0);
            mem_rvalid = 1'b0;
            #1;
            if (bus_err === 1'b1) begin
                seen = k;
                check("to_err_req", mem_req, 1'b0);
                check("to_err_stall", stall, 1'b1);
            end
        end
        check("to_err_cycle", 32'(seen), 32'(TO));
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("to_pulse_len", bus_err, 1'b0);
        check("to_done_stall", stall, 1'b0);
        if (is_read) check("to_done_rdata", rdata, 32'h0);
        memread = 1'b0; memwrite = 1'b0;
        if (seen < 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        @(negedge clk); #1;
        check("to_back_idle", stall, 1'b0);
    endtask

    initial begin
        logic        rd, wr, uns, mis;
        logic [1:0]  sz;
        logic [31:0] a, wd, rdat, mwd, rres;
        logic [3:0]  be;

        //        rd  wr  sz    uns a             wd            rdat          g  mis be       mwd           rres
        tbl[0]  = '{0, 1, 2'd2, 0, 32'h100,  32'hDEADBEEF, 32'h0,        1, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1, 0, 2'd0, 0, 32'h203,  32'h0,        32'h80FFFFFF, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1, 0, 2'd0, 1, 32'h203,  32'h0,        32'h80FFFFFF, 0, 0, 4'b1000, 32'h0,        32'h00000080};
        tbl[3]  = '{0, 1, 2'd1, 0, 32'h0002, 32'h00001234, 32'h0,        0, 0, 4'b1100, 32'h12341234, 32'h0};
        tbl[4]  = '{1, 0, 2'd2, 0, 32'h0006, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
        tbl[5]  = '{1, 0, 2'd1, 0, 32'h012,  32'h0,        32'h80017FFF, 2, 0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[6]  = '{1, 0, 2'd1, 1, 32'h010,  32'h0,        32'h12349ABC, 0, 0, 4'b0011, 32'h0,        32'h00009ABC};
        tbl[7]  = '{1, 1, 2'd0, 0, 32'h021,  32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        tbl[8]  = '{1, 0, 2'd3, 0, 32'h044,  32'h0,        32'hCAFEF00D, 1, 0, 4'b1111, 32'h0,        32'hCAFEF00D};
        tbl[9]  = '{0, 1, 2'd1, 0, 32'h003,  32'h0000BEEF, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
        tbl[10] = '{1, 0, 2'd0, 0, 32'h001,  32'h0,        32'h00007F00, 0, 0, 4'b0010, 32'h0,        32'h0000007F};

        reset = 1'b1; memread = 1'b1; memwrite = 1'b0; size = 2'b10; ld_unsigned = 1'b0;
        addr = 32'h100; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk); #1;
        check("rst_stall", stall, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_be", mem_be, 4'b0000);
        addr = 32'h102;
        #1;
        check("rst_mis", misalign, 1'b0);
        memread = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
                       tbl[i].rdat, tbl[i].gdly, 1, tbl[i].mis, tbl[i].be, tbl[i].mwd, tbl[i].rres);

        @(negedge clk);
        addr = $urandom; wdata = $urandom; size = 2'b01;
        #1;
        check("idle_ctrl", {28'h0, stall, misalign, bus_err, mem_req}, 32'h0);
        check("idle_bus", {27'h0, mem_we, mem_be}, 32'h0);
        check("idle_addr", mem_addr, 32'h0);
        check("idle_wdata", mem_wdata, 32'h0);
        check("idle_rdata", rdata, 32'h0);

        for (int i = 0; i < 80; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            model(sz, uns, a, wd, rdat, mis, be, mwd, rres);
            run_access(rd, wr, sz, uns, a, wd, rdat, $urandom_range(0, 3),
                       $urandom_range(0, 3), mis, be, mwd, rres);
        end

        run_timeout(1'b1);
        run_timeout(1'b0);

        // Reset while waiting for read data; a late rvalid must be ignored.
        @(negedge clk);
        memread = 1'b1; memwrite = 1'b0; size = 2'b10; addr = 32'h80;
        #1;
        check("rw_idle_stall", stall, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        check("rw_req", mem_req, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rw_wait_stall", stall, 1'b1);
        reset = 1'b1;
        #1;
        check("rw_rst_stall", stall, 1'b0);
        check("rw_rst_req", mem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0; memread = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        #1;
        check("rw_post_stall", stall, 1'b0);
        check("rw_post_rdata", rdata, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("rw_late_stall", stall, 1'b0);
        check("rw_late_rdata", rdata, 32'h0);
        check("rw_late_req", mem_req, 1'b0);

        model(2'd0, 1'b0, 32'h301, 32'h0, 32'h0000C300, mis, be, mwd, rres);
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h301, 32'h0, 32'h0000C300, 0, 0, mis, be, mwd, rres);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
